// File: rtl/screen_scan_arbiter_pkg.sv
// screen_pkg: shared constants and the arbiter grant encoding for the
// screen memory scan/CPU arbiter.
//   SCREEN_ADDR_W / SCREEN_DATA_W : default word address / word widths
//   SCREEN_WORDS                  : words per frame (8K)
//   ROW_WORDS / ROWS              : display geometry (32 words x 256 rows)
//   gnt_t                         : which requester owns the RAM this cycle
package screen_pkg;

  localparam int SCREEN_ADDR_W = 13;
  localparam int SCREEN_DATA_W = 16;
  localparam int SCREEN_WORDS  = 8192;
  localparam int ROW_WORDS     = 32;
  localparam int ROWS          = 256;

  typedef enum logic [1:0] {
    GNT_NONE        = 2'd0,
    GNT_SCAN_URGENT = 2'd1,
    GNT_CPU         = 2'd2,
    GNT_SCAN        = 2'd3
  } gnt_t;

endpackage

// File: rtl/screen_scan_arbiter_fifo.sv
// scan_fifo: 2-entry synchronous prefetch FIFO between the screen RAM read
// port and the pixel shifter.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : synchronous clear (pointers and count), data slots untouched
//   push/wdata : write one word; ignored when full unless a pop happens too
//   pop        : discard the head word; ignored when empty
//   rdata      : head word (combinational, meaningful while count != 0)
//   count      : number of stored words, 0..2
// Push and pop in the same cycle are both honoured and leave count unchanged.
module scan_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] slot [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign rdata   = slot[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      slot[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/screen_scan_arbiter.sv
// screen_scan_arbiter: shares the single-port screen RAM between the CPU and
// the raster scan-out engine, one RAM access per cycle.
//   clk, rst_n          : clock, synchronous active-low reset
//   scan_en             : 1 = scanner running, 0 = scanner idle and flushed
//   pix_en              : pixel strobe, one pixel per accepted strobe
//   cpu_req/we/addr/wdata, cpu_ack/rdata : CPU access port
//   mem_addr/in/load, mem_out            : screen RAM port (combinational read)
//   pix, pix_valid      : serialised pixel (LSB of each word first)
//   line_start          : with the first pixel of each row
//   frame_start         : with the first pixel of word 0
//   underrun            : sticky, strobe seen with no pixel data available
//
// CPU handshake: cpu_req is held with stable we/addr/wdata until cpu_ack.
// cpu_ack is a one-cycle pulse in the cycle after the RAM access; read data
// is valid on cpu_rdata while cpu_ack=1. A new request may be presented in
// the ack cycle; it is granted no earlier than the following cycle.
module screen_scan_arbiter
  import screen_pkg::*;
#(
  parameter int ADDR_W    = screen_pkg::SCREEN_ADDR_W,
  parameter int DATA_W    = screen_pkg::SCREEN_DATA_W,
  parameter int ROW_WORDS = screen_pkg::ROW_WORDS,
  parameter int ROWS      = screen_pkg::ROWS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic              pix_en,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic              pix,
  output logic              pix_valid,
  output logic              line_start,
  output logic              frame_start,
  output logic              underrun
);

  localparam int                IDX_W       = $clog2(DATA_W);
  localparam int                FRAME_WORDS = ROW_WORDS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DATA_W - 1);

  gnt_t              gnt;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;

  logic              sh_valid;
  logic [DATA_W-1:0] sh_word;
  logic [DATA_W-1:0] cur_word;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] sh_addr;    // frame address of the word being shifted
  logic [ADDR_W-1:0] scan_addr;  // next word to fetch
  logic              avail;
  logic              take;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // An empty shifter can still serve a pixel straight from the FIFO head,
  // so a freshly fetched word is usable in the very next cycle.
  assign avail    = sh_valid || (fifo_count != 2'd0);
  assign cur_word = sh_valid ? sh_word : fifo_rdata;
  assign take     = scan_en && pix_en && avail;

  assign fifo_push  = (gnt == GNT_SCAN_URGENT) || (gnt == GNT_SCAN);
  assign fifo_pop   = take && (!sh_valid || ((idx == LAST_IDX) && (fifo_count != 2'd0)));
  assign fifo_flush = !scan_en;

  scan_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (mem_out),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  // Grant: urgent scan fetch beats the CPU only when no pixel data is held
  // anywhere, which bounds the CPU wait to a single extra cycle. Gated by
  // reset so a request held through reset causes no RAM write.
  always_comb begin
    gnt = GNT_NONE;
    if (rst_n) begin
      if (scan_en && !avail) begin
        gnt = GNT_SCAN_URGENT;
      end else if (cpu_req && !cpu_ack) begin
        gnt = GNT_CPU;
      end else if (scan_en && (fifo_count != 2'd2)) begin
        gnt = GNT_SCAN;
      end
    end
  end

  always_comb begin
    mem_addr = scan_addr;
    mem_in   = '0;
    mem_load = 1'b0;
    if (gnt == GNT_CPU) begin
      mem_addr = cpu_addr;
      mem_in   = cpu_wdata;
      mem_load = cpu_we;
    end
  end

  // CPU completion registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= (gnt == GNT_CPU);
      if ((gnt == GNT_CPU) && !cpu_we) begin
        cpu_rdata <= mem_out;
      end
    end
  end

  // Scan address counter and pixel shifter.
  always_ff @(posedge clk) begin
    if (!rst_n || !scan_en) begin
      scan_addr   <= '0;
      sh_valid    <= 1'b0;
      sh_word     <= '0;
      sh_addr     <= '0;
      idx         <= '0;
      pix         <= 1'b0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (fifo_push) begin
        scan_addr <= next_addr(scan_addr);
      end
      pix_valid <= pix_en;
      if (take) begin
        pix         <= cur_word[idx];
        line_start  <= (idx == '0) && ((sh_addr % ADDR_W'(ROW_WORDS)) == '0);
        frame_start <= (idx == '0) && (sh_addr == '0);
        if (!sh_valid) begin
          // First pixel came from the FIFO head; that word moves in now.
          sh_word  <= fifo_rdata;
          sh_valid <= 1'b1;
          idx      <= idx + 1'b1;
        end else if (idx == LAST_IDX) begin
          idx     <= '0;
          sh_addr <= next_addr(sh_addr);
          if (fifo_count != 2'd0) begin
            sh_word <= fifo_rdata;
          end else begin
            sh_valid <= 1'b0;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        pix         <= 1'b0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
        if (pix_en) begin
          // Position is held so the missing pixel is shown late, not skipped.
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_screen_scan_arbiter.sv
module tb_screen_scan_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        scan_en;
  logic        pix_en;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [12:0] mem_addr;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [15:0] mem_out;
  logic        pix;
  logic        pix_valid;
  logic        line_start;
  logic        frame_start;
  logic        underrun;

  int tests  = 0;
  int failed = 0;

  screen_scan_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .pix_en      (pix_en),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .mem_addr    (mem_addr),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_out     (mem_out),
    .pix         (pix),
    .pix_valid   (pix_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  // ---------------- screen RAM model (single writer process) ----------------
  logic [15:0] ram [0:8191];
  logic        bd_clear;
  logic        bd_we;
  logic [12:0] bd_addr;
  logic [15:0] bd_data;
  int          load_cnt;

  assign mem_out = ram[mem_addr];

  always @(posedge clk) begin
    if (bd_clear) begin
      for (int i = 0; i < 8192; i++) ram[i] <= '0;
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_load) begin
      ram[mem_addr] <= mem_in;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) load_cnt <= 0;
    else if (mem_load) load_cnt <= load_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word pattern used for scan data: high byte = index, low byte = ~index.
  function automatic logic [15:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b};
  endfunction

  // Bounded CPU access; returns in the ack cycle (or after the bound).
  task automatic cpu_access(input logic we, input logic [12:0] a, input logic [15:0] d,
                            output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu_ack && lat < 10);
    cpu_req = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int          lat;
    int          pix_err;
    int          mk_err;
    int          rd_err;
    int          dis_err;
    int          n_line;
    int          n_ack;
    int          rd_n;
    int          cyc;
    int          lat_max;
    logic [3:0]  pix_first;
    logic        f0, l0, p511, last_pix;
    logic [15:0] w;

    rst_n = 1'b0; scan_en = 1'b0; pix_en = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0055; cpu_wdata = 16'hDEAD;
    bd_clear = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // Reset held 2 cycles with a write request pending.
    tick();
    bd_clear = 1'b0;
    chk("rst_mem_load_c1", mem_load, 1'b0);
    tick();
    chk("rst_mem_load", mem_load, 1'b0);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_mem_addr", mem_addr, 13'h0);
    chk("rst_outputs", {cpu_rdata, pix, pix_valid, line_start, frame_start, underrun}, '0);
    chk("rst_mem_in", mem_in, 16'h0);
    cpu_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // CPU write / read with scanner idle.
    cpu_access(1'b1, 13'h0000, 16'hA0AA, lat);
    chk("wr0_lat", lat, 1);
    chk("wr0_loads", load_cnt, 1);
    tick();
    cpu_access(1'b1, 13'h0015, 16'hFFFF, lat);
    chk("wr1_lat", lat, 1);
    tick();
    cpu_access(1'b1, 13'h0067, 16'h1234, lat);
    chk("wr2_lat", lat, 1);
    tick();
    chk("wr_loads_total", load_cnt, 3);
    cpu_access(1'b0, 13'h0000, 16'h0, lat);
    chk("rd0_lat", lat, 1);
    chk("rd0_data", cpu_rdata, 16'hA0AA);
    tick();
    cpu_access(1'b0, 13'h0015, 16'h0, lat);
    chk("rd1_data", cpu_rdata, 16'hFFFF);
    tick();
    cpu_access(1'b0, 13'h0067, 16'h0, lat);
    chk("rd2_lat", lat, 1);
    chk("rd2_data", cpu_rdata, 16'h1234);
    tick();
    chk("rd_no_loads", load_cnt, 3);

    // Scan-out of row 0 with word0=0005, word31=8000.
    cpu_access(1'b1, 13'h0000, 16'h0005, lat);
    tick();
    cpu_access(1'b1, 13'h001F, 16'h8000, lat);
    tick();
    scan_en = 1'b1;
    tick();
    pix_en = 1'b1;
    n_line = 0; pix_first = '0; f0 = 1'b0; l0 = 1'b0; p511 = 1'b0;
    for (int k = 0; k < 512; k++) begin
      tick();
      if (k < 4) pix_first[k] = pix;
      if (k == 0) begin f0 = frame_start; l0 = line_start; end
      if (line_start) n_line++;
      if (k == 511) p511 = pix;
    end
    chk("scan_first4", {28'h0, pix_first}, 32'h5);
    chk("scan_frame_start0", f0, 1'b1);
    chk("scan_line_start0", l0, 1'b1);
    chk("scan_line_count_row0", n_line, 1);
    chk("scan_pix511", p511, 1'b1);
    tick();
    chk("scan_line_start_w32", {pix_valid, line_start, frame_start}, 3'b110);

    // Contention: continuous pixels plus back-to-back CPU reads.
    scan_en = 1'b0; pix_en = 1'b0;
    tick();
    for (int i = 0; i < 64; i++) begin
      bd_we = 1'b1; bd_addr = 13'(i); bd_data = pat(i);
      tick();
    end
    bd_we = 1'b0;
    scan_en = 1'b1;
    tick();
    pix_en = 1'b1;
    rd_n = 0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0;
    pix_err = 0; mk_err = 0; rd_err = 0; n_ack = 0; cyc = 0; lat_max = 0;
    for (int k = 0; k < 1024; k++) begin
      tick();
      cyc++;
      w = pat(k / 16);
      if (!pix_valid || pix !== w[k % 16]) pix_err++;
      if (frame_start !== (k == 0)) mk_err++;
      if (line_start !== (k % 512 == 0)) mk_err++;
      if (cpu_ack) begin
        if (cpu_rdata !== pat(rd_n % 64)) rd_err++;
        if (cyc > lat_max) lat_max = cyc;
        n_ack++;
        rd_n++;
        cpu_addr = 13'(rd_n % 64);
        cyc = 0;
      end
    end
    cpu_req = 1'b0;
    chk("cont_pixels", pix_err, 0);
    chk("cont_markers", mk_err, 0);
    chk("cont_rdata", rd_err, 0);
    chk("cont_lat_le2", lat_max <= 2, 1'b1);
    chk("cont_ack_count", n_ack > 400, 1'b1);
    chk("cont_no_underrun", underrun, 1'b0);

    // Underrun: pixel strobe in the enabling cycle.
    scan_en = 1'b0; pix_en = 1'b0;
    tick();
    scan_en = 1'b1; pix_en = 1'b1;
    tick();
    chk("ur_cycle", {pix_valid, pix, underrun, frame_start}, 4'b1010);
    tick();
    chk("ur_pixel0", {pix_valid, pix, frame_start, underrun}, 4'b1111);
    scan_en = 1'b0;
    tick();
    chk("ur_cleared", {underrun, pix_valid}, 2'b00);

    // Disable mid-row at word 5 idx 7, re-enable 3 cycles later.
    pix_en = 1'b0; scan_en = 1'b1;
    tick();
    pix_en = 1'b1; pix_err = 0; last_pix = 1'b0;
    for (int k = 0; k < 88; k++) begin
      tick();
      w = pat(k / 16);
      if (!pix_valid || pix !== w[k % 16]) pix_err++;
      last_pix = pix;
    end
    chk("mid_pixels", pix_err, 0);
    chk("mid_w5_i7", last_pix, 1'b1);
    scan_en = 1'b0; dis_err = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (pix_valid || line_start || frame_start) dis_err++;
    end
    chk("dis_quiet", dis_err, 0);
    pix_en = 1'b0; scan_en = 1'b1;
    tick();
    pix_en = 1'b1; pix_err = 0; mk_err = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      w = pat(k / 16);
      if (!pix_valid || pix !== w[k % 16]) pix_err++;
      if (frame_start !== (k == 0)) mk_err++;
    end
    chk("restart_pixels", pix_err, 0);
    chk("restart_frame_start", mk_err, 0);
    chk("restart_no_underrun", underrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
